// File: rtl/leaf_group_router.sv
// leaf_group_router: terminates the NI router-side links of one GPU group.
// Five input FIFOs (local leaves 0..N_LEAF-1, uplink = N_LEAF) feed five
// round-robin arbitrated, registered outputs. Flits whose group matches
// GROUP_ID go to the leaf named in the header, other local flits go up.
// Header 0 and uplink flits for a foreign group are dropped.
// Optional macro ROUTE_ERR_CNT_EN enables the saturating dropped-flit
// counter on err_count; without it err_count is tied to zero.
module leaf_group_router #(
  parameter int GROUP_ID   = 2,
  parameter int DATA_W     = 16,
  parameter int HEADER_W   = 6,
  parameter int N_LEAF     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_LEAF*DATA_W-1:0]   loc_data_in,
  input  logic [N_LEAF-1:0]          loc_valid_in,
  output logic [N_LEAF-1:0]          loc_ready_out,
  output logic [N_LEAF*DATA_W-1:0]   loc_data_out,
  output logic [N_LEAF-1:0]          loc_valid_out,
  output logic [DATA_W-1:0]          up_data_out,
  output logic                       up_valid_out,
  input  logic                       up_ready_in,
  input  logic [DATA_W-1:0]          up_data_in,
  input  logic                       up_valid_in,
  output logic                       up_ready_out,
  output logic [7:0]                 err_count
);

  localparam int N_IN   = N_LEAF + 1;
  localparam int UP     = N_LEAF;
  localparam int OUT_W  = $clog2(N_IN);
  localparam int LEAF_W = $clog2(N_LEAF);
  localparam int GRP_W  = HEADER_W - LEAF_W;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [GRP_W-1:0] MY_GROUP   = GRP_W'(GROUP_ID);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FIFO_DEPTH);
  // one flit may already be in flight from the NI when credit is granted
  localparam logic [CNT_W-1:0] CREDIT_CNT = CNT_W'(FIFO_DEPTH - 2);
  localparam logic [OUT_W:0]   N_IN_W     = (OUT_W + 1)'(N_IN);

  // (base + off) mod N_IN, both operands already below N_IN
  function automatic logic [OUT_W-1:0] rr_idx(input logic [OUT_W-1:0] base,
                                              input logic [OUT_W-1:0] off);
    logic [OUT_W:0] s;
    s = {1'b0, base} + {1'b0, off};
    if (s >= N_IN_W) s = s - N_IN_W;
    return s[OUT_W-1:0];
  endfunction

  logic [N_IN-1:0]   wr_en;
  logic [N_IN-1:0]   pop;
  logic [N_IN-1:0]   drop;
  logic [N_IN-1:0]   req_valid;
  logic [N_IN-1:0]   gnt_any;
  logic [DATA_W-1:0] head    [N_IN];
  logic [OUT_W-1:0]  dest    [N_IN];
  logic [OUT_W-1:0]  gnt_idx [N_IN];

  logic              up_valid_reg;
  logic [DATA_W-1:0] up_data_reg;

  genvar gi;

  // ---------------- input FIFOs and head route decode ----------------
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_in
      logic [DATA_W-1:0]   mem [FIFO_DEPTH];
      logic [PTR_W-1:0]    wr_ptr_reg;
      logic [PTR_W-1:0]    rd_ptr_reg;
      logic [CNT_W-1:0]    cnt_reg;
      logic [DATA_W-1:0]   din;
      logic [HEADER_W-1:0] hdr;
      logic [GRP_W-1:0]    grp;
      logic [LEAF_W-1:0]   leaf;
      logic                head_valid;
      logic                misroute;

      if (gi < N_LEAF) begin : g_loc
        assign din               = loc_data_in[gi*DATA_W +: DATA_W];
        // credit flow guarantees room; the guard only protects pointers
        assign wr_en[gi]         = loc_valid_in[gi] && ((cnt_reg != FULL_CNT) || pop[gi]);
        assign loc_ready_out[gi] = (cnt_reg <= CREDIT_CNT);
        assign misroute          = 1'b0;
      end else begin : g_up
        assign din          = up_data_in;
        assign wr_en[gi]    = up_valid_in && up_ready_out;
        assign up_ready_out = (cnt_reg != FULL_CNT);
        // a flit from the parent must belong to this group
        assign misroute     = (grp != MY_GROUP);
      end

      assign head[gi]      = mem[rd_ptr_reg];
      assign head_valid    = (cnt_reg != '0);
      assign hdr           = head[gi][DATA_W-1 -: HEADER_W];
      assign grp           = hdr[HEADER_W-1 -: GRP_W];
      assign leaf          = hdr[LEAF_W-1:0];
      assign drop[gi]      = head_valid && ((hdr == '0) || misroute);
      assign req_valid[gi] = head_valid && !drop[gi];
      assign dest[gi]      = (grp == MY_GROUP) ? OUT_W'(leaf) : OUT_W'(UP);
      assign pop[gi]       = drop[gi] ||
                             (req_valid[gi] && gnt_any[dest[gi]] &&
                              (gnt_idx[dest[gi]] == OUT_W'(gi)));

      // FIFO storage write port
      always_ff @(posedge clk) begin
        if (wr_en[gi]) mem[wr_ptr_reg] <= din;
      end

      // FIFO pointers and occupancy; simultaneous write and pop keep count
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          cnt_reg    <= '0;
        end else begin
          if (wr_en[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (pop[gi])   rd_ptr_reg <= rd_ptr_reg + 1'b1;
          if (wr_en[gi] && !pop[gi])      cnt_reg <= cnt_reg + 1'b1;
          else if (!wr_en[gi] && pop[gi]) cnt_reg <= cnt_reg - 1'b1;
        end
      end
    end
  endgenerate

  // ---------------- per-output round-robin arbiters ----------------
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_arb
      logic [OUT_W-1:0] rr_ptr_reg;   // highest-priority input this cycle
      logic [OUT_W-1:0] idx_c;
      logic [OUT_W-1:0] cand;
      logic             any_c;
      logic             out_ok;

      if (gi == UP) begin : g_upok
        // uplink may take a flit when empty or when its flit leaves now
        assign out_ok = !up_valid_reg || up_ready_in;
      end else begin : g_lok
        assign out_ok = 1'b1;
      end

      // first requester found scanning from rr_ptr_reg upward
      always_comb begin
        any_c = 1'b0;
        idx_c = '0;
        cand  = '0;
        for (int off = 0; off < N_IN; off++) begin
          cand = rr_idx(rr_ptr_reg, OUT_W'(off));
          if (!any_c && out_ok && req_valid[cand] && (dest[cand] == OUT_W'(gi))) begin
            any_c = 1'b1;
            idx_c = cand;
          end
        end
      end

      assign gnt_any[gi] = any_c;
      assign gnt_idx[gi] = idx_c;

      // priority moves past the winner, only when something is granted
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   rr_ptr_reg <= '0;
        else if (any_c) rr_ptr_reg <= rr_idx(idx_c, OUT_W'(1));
      end
    end
  endgenerate

  // ---------------- registered local outputs ----------------
  generate
    for (gi = 0; gi < N_LEAF; gi++) begin : g_lout
      logic              valid_reg;
      logic [DATA_W-1:0] data_reg;

      // one-cycle valid pulse per granted flit; data holds between flits
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          valid_reg <= 1'b0;
          data_reg  <= '0;
        end else begin
          valid_reg <= gnt_any[gi];
          if (gnt_any[gi]) data_reg <= head[gnt_idx[gi]];
        end
      end

      assign loc_valid_out[gi]                 = valid_reg;
      assign loc_data_out[gi*DATA_W +: DATA_W] = data_reg;
    end
  endgenerate

  // uplink output register: load on grant, clear once accepted, else hold
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      up_valid_reg <= 1'b0;
      up_data_reg  <= '0;
    end else if (gnt_any[UP]) begin
      up_valid_reg <= 1'b1;
      up_data_reg  <= head[gnt_idx[UP]];
    end else if (up_ready_in) begin
      up_valid_reg <= 1'b0;
    end
  end

  assign up_valid_out = up_valid_reg;
  assign up_data_out  = up_data_reg;

  // ---------------- dropped-flit counter ----------------
`ifdef ROUTE_ERR_CNT_EN
  logic [7:0] err_count_reg;
  logic [8:0] err_sum;

  assign err_sum = {1'b0, err_count_reg} + 9'($countones(drop));

  // add all drops of this cycle, saturating at 8'hFF
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_count_reg <= '0;
    else          err_count_reg <= err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  assign err_count = err_count_reg;
`else
  assign err_count = '0;
`endif

endmodule

// File: doc/leaf_group_router.md
Name: leaf_group_router

Overview:
- Group-level router on the far side of the GPU network interfaces. Terminates the NI router-side link for the four GPUs of one group.
- Each flit is 16 bits: header[15:10] = {group[3:0], leaf[1:0]}, payload[9:0].
- Flits whose group matches GROUP_ID go to the local leaf port; all others go to the uplink.
- Flits arriving on the uplink are delivered to local leaves.

Parameters:
GROUP_ID, 2, 4-bit group number of this router (GPUs 5-8 for default)
DATA_W, 16, flit width
HEADER_W, 6, routing header width (4 group + 2 leaf)
N_LEAF, 4, local ports; fixed by 2-bit leaf field
FIFO_DEPTH, 4, per-input FIFO depth; power of two, >=4

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
loc_data_in  in  N_LEAF*DATA_W  flits from NI i (slice i)
loc_valid_in  in  N_LEAF  flit valid from NI i
loc_ready_out  out  N_LEAF  credit to NI i (drives NI pop)
loc_data_out  out  N_LEAF*DATA_W  flits to NI i
loc_valid_out  out  N_LEAF  valid to NI i; no backpressure
up_data_out  out  DATA_W  flit to parent
up_valid_out  out  1  uplink valid
up_ready_in  in  1  parent accepts
up_data_in  in  DATA_W  flit from parent
up_valid_in  in  1  parent valid
up_ready_out  out  1  router accepts uplink flit
err_count  out  8  dropped-flit counter (see Optional Feature)

Behaviour:
- Reset (reset_n=0, async): all FIFOs empty, all pointers 0, round-robin pointers 0. All *_valid_out=0, all *_data_out=0, err_count=0. up_ready_out=1 and loc_ready_out=all-ones after release. Reset mid-operation discards every buffered flit and every in-flight flit.
- Inputs 0..3 = local, 4 = uplink. Each input has a FIFO_DEPTH FIFO. Count width is log2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Local input credit: the NI pops its FIFO on the clock where it samples ready and presents valid on the next cycle. loc_ready_out[i] = (count_i <= FIFO_DEPTH-2), so one in-flight flit always fits. loc_valid_in[i] is always accepted. Overflow must not occur; it is an assertion in the bench.
- Uplink input: standard valid/ready in the same cycle. up_ready_out = !full. A flit is written when up_valid_in && up_ready_out.
- Route decode on the FIFO head:
  - header==0 → drop (pop, no output).
  - group==GROUP_ID → local port leaf.
  - Otherwise, local inputs → uplink (output 4).
  - Uplink input with group!=GROUP_ID → misroute, drop.
  - Hairpin (local input to its own leaf) is legal.
- Arbitration: one round-robin arbiter per output over the 5 inputs. Priority starts at last_grant+1 mod 5. The pointer updates only on a grant. An input requests exactly one output, so there is at most one grant per input per cycle. A granted head is popped the same edge.
- Local outputs are registered. loc_valid_out[k]=1 for exactly one cycle per granted flit, otherwise 0. loc_data_out holds its last value when valid=0.
- Uplink output is registered with hold:
  - While up_valid_out && !up_ready_in, data and valid are frozen and the uplink output is not granted.
  - A grant occurs when the register is empty or is being accepted this cycle (back-to-back throughput 1/cycle).
- Latency: a flit written at edge N (FIFO empty, no contention) appears with valid after edge N+1.
- Simultaneous write and pop on the same FIFO: count unchanged, both pointers advance.
- Headers are forwarded unchanged; header-to-GPU-ID translation is done in the NI.

Optional Feature:
- Macro ROUTE_ERR_CNT_EN.
- Defined: err_count increments on each dropped flit (header 0 or uplink misroute) and saturates at 8'hFF. Multiple drops in one cycle add their sum, saturating.
- Undefined: err_count is tied to 0. Drop behaviour is identical either way.

Test Plan:
- GROUP_ID=2; loc0 sends 0x2D55 (GPU8 = hdr 001011, payload 0x155) → loc_valid_out[3] for 1 cycle, loc_data_out[3]=0x2D55, 2 edges after the sample.
- loc1 sends 0x40AA (GPU13, group 4) with up_ready_in=0 for 3 cycles → up_valid_out=1 and up_data_out=0x40AA held stable, released on the first ready cycle. The next flit follows back-to-back.
- loc0, loc1, loc2 each send to leaf 2 (0x2800, 0x2801, 0x2802) in the same cycle → loc_out[2] emits them in round-robin order 0x2800, 0x2801, 0x2802 on consecutive cycles. A repeat burst starts from input 3/4 priority.
- All 5 inputs stream continuously to leaf 0 → loc_ready_out[i] deasserts when count reaches DEPTH-1. No FIFO overflow; every flit is delivered; the output is busy every cycle.
- With ROUTE_ERR_CNT_EN: loc3 sends 0x0123, and the uplink sends 0x4000 (group 4) → both dropped, err_count=2, no outputs. Without the macro, err_count stays 0.
- Assert reset_n low with 3 flits buffered → all valids 0 immediately (async). After release, no stale flits are emitted and the credits are all-ones.
